// File: rtl/itf_req_sched.sv
// Off-chip request scheduler: port 0 first, then urgent ports, then pending ports round-robin; cmd_vld 2 cycles after request,
// held until cmd_rdy, next arbitration only after xfer_done. Defining ITF_SCHED_AGE_EN promotes ports passed over AGE_LIMIT times.
module itf_req_sched #(
    parameter int NUM_WRPORT      = 4,
    parameter int NUM_RDPORT      = 2,
    parameter int ADDR_WIDTH      = 16,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int AGE_LIMIT       = 8
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic [NUM_WRPORT+NUM_RDPORT-1:0]                    req_urgent,
    input  logic [ADDR_WIDTH*(NUM_WRPORT+NUM_RDPORT)-1:0]       req_num,
    input  logic [ADDR_WIDTH*(NUM_WRPORT+NUM_RDPORT)-1:0]       req_addr,
    input  logic [DRAM_ADDR_WIDTH*(NUM_WRPORT+NUM_RDPORT)-1:0]  base_addr,
    output logic                                                cmd_vld,
    input  logic                                                cmd_rdy,
    output logic [$clog2(NUM_WRPORT+NUM_RDPORT)-1:0]            cmd_port,
    output logic [ADDR_WIDTH-1:0]                               cmd_num,
    output logic [DRAM_ADDR_WIDTH-1:0]                          cmd_addr,
    output logic                                                cmd_rd,
    output logic [NUM_WRPORT+NUM_RDPORT-1:0]                    gnt,
    input  logic                                                xfer_done,
    output logic                                                busy
);
    localparam int N  = NUM_WRPORT + NUM_RDPORT;
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {IDLE, ARB, GRANT, BUSY} state_t;

    state_t                     state, stateNxt;
    logic [PW-1:0]              rrPtr;
    logic [ADDR_WIDTH-1:0]      numArr  [N];
    logic [ADDR_WIDTH-1:0]      addrArr [N];
    logic [DRAM_ADDR_WIDTH-1:0] baseArr [N];
    logic [N-1:0]               pending, eligible, aged, urgent;
    logic                       urgFound, nrmFound, winFound, grantEv;
    logic [PW-1:0]              urgIdx, nrmIdx, winIdx, scanIdx;
    logic [PW:0]                scanSum;

    for (genvar g = 0; g < N; g++) begin : gUnpack
        assign numArr[g]  = req_num[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign addrArr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign baseArr[g] = base_addr[g*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
        assign pending[g] = |numArr[g];
    end

    assign eligible = pending | req_urgent;
    assign urgent   = req_urgent | aged;

    // Two round-robin scans from rrPtr share one loop: urgent class and plain-pending class.
    always_comb begin
        urgFound = 1'b0;
        nrmFound = 1'b0;
        urgIdx   = '0;
        nrmIdx   = '0;
        scanSum  = '0;
        scanIdx  = '0;
        winIdx   = '0;
        for (int off = 0; off < N; off++) begin
            scanSum = {1'b0, rrPtr} + (PW+1)'(off);
            if (scanSum >= (PW+1)'(N))
                scanSum = scanSum - (PW+1)'(N);
            scanIdx = scanSum[PW-1:0];
            if (!urgFound && urgent[scanIdx]) begin
                urgFound = 1'b1;
                urgIdx   = scanIdx;
            end
            if (!nrmFound && pending[scanIdx]) begin
                nrmFound = 1'b1;
                nrmIdx   = scanIdx;
            end
        end
        winFound = |eligible;
        if (eligible[0])
            winIdx = '0;
        else if (urgFound)
            winIdx = urgIdx;
        else
            winIdx = nrmIdx;
    end

    assign grantEv = (state == ARB) && winFound;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (|eligible) stateNxt = ARB;
            ARB:     stateNxt = winFound ? GRANT : IDLE;
            GRANT:   if (cmd_rdy) stateNxt = BUSY;
            BUSY:    if (xfer_done) stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr    <= PW'(1);
            cmd_port <= '0;
            cmd_num  <= '0;
            cmd_addr <= '0;
            cmd_rd   <= 1'b0;
            gnt      <= '0;
        end else if (grantEv) begin
            cmd_port <= winIdx;
            cmd_num  <= numArr[winIdx];
            cmd_addr <= baseArr[winIdx] + DRAM_ADDR_WIDTH'(addrArr[winIdx]);
            cmd_rd   <= ({1'b0, winIdx} >= (PW+1)'(NUM_WRPORT));
            gnt      <= N'(1) << winIdx;
            // The CCU port bypasses the rotation so it cannot steal fairness from the others.
            if (winIdx != '0)
                rrPtr <= (winIdx == PW'(N-1)) ? '0 : winIdx + 1'b1;
        end else if ((state == BUSY) && xfer_done) begin
            gnt <= '0;
        end
    end

    assign cmd_vld = (state == GRANT);
    assign busy    = (state != IDLE);

`ifdef ITF_SCHED_AGE_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);

    logic [AW-1:0] age [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                age[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] || (grantEv && (winIdx == PW'(i))))
                    age[i] <= '0;
                else if (grantEv && (age[i] != AW'(AGE_LIMIT)))
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : gAged
        assign aged[g] = pending[g] && (age[g] == AW'(AGE_LIMIT));
    end
`else
    logic unusedAgeLimit;

    assign aged           = '0;
    assign unusedAgeLimit = |AGE_LIMIT;
`endif

endmodule

// File: tb/tb_itf_req_sched.sv
// Bench for itf_req_sched: directed request patterns push hand-computed commands into a queue,
// a negedge monitor pops one per cmd_vld rise and compares every cycle the command is held.
module tb_itf_req_sched;
    localparam int N = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_urgent;
    logic [16*N-1:0] req_num;
    logic [16*N-1:0] req_addr;
    logic [32*N-1:0] base_addr;
    logic            cmd_vld;
    logic            cmd_rdy;
    logic [2:0]      cmd_port;
    logic [15:0]     cmd_num;
    logic [31:0]     cmd_addr;
    logic            cmd_rd;
    logic [N-1:0]    gnt;
    logic            xfer_done;
    logic            busy;

    logic        urg  [N];
    logic [15:0] num  [N];
    logic [15:0] adr  [N];
    logic [31:0] base [N];

    typedef struct packed {
        logic [2:0]  port;
        logic [15:0] num;
        logic [31:0] addr;
        logic        rd;
    } exp_t;

    exp_t expQ [$];
    exp_t cur;
    bit   haveCur = 1'b0;
    bit   prevVld = 1'b0;
    int   vecCnt  = 0;
    int   errCnt  = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_urgent[i]          = urg[i];
            req_num[i*16 +: 16]    = num[i];
            req_addr[i*16 +: 16]   = adr[i];
            base_addr[i*32 +: 32]  = base[i];
        end
    end

    itf_req_sched #(
        .NUM_WRPORT      (4),
        .NUM_RDPORT      (2),
        .ADDR_WIDTH      (16),
        .DRAM_ADDR_WIDTH (32),
        .AGE_LIMIT       (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_urgent (req_urgent),
        .req_num    (req_num),
        .req_addr   (req_addr),
        .base_addr  (base_addr),
        .cmd_vld    (cmd_vld),
        .cmd_rdy    (cmd_rdy),
        .cmd_port   (cmd_port),
        .cmd_num    (cmd_num),
        .cmd_addr   (cmd_addr),
        .cmd_rd     (cmd_rd),
        .gnt        (gnt),
        .xfer_done  (xfer_done),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input int p, input logic [15:0] n, input logic [31:0] a, input logic rd);
        exp_t e;
        e.port = 3'(p);
        e.num  = n;
        e.addr = a;
        e.rd   = rd;
        expQ.push_back(e);
    endtask

    task automatic waitVld(input int budget);
        int n = 0;
        while (!cmd_vld && n < budget) begin
            cyc(1);
            n++;
        end
        if (!cmd_vld) begin
            vecCnt++;
            errCnt++;
            $display("FAIL wait_vld: cmd_vld still 0 after %0d cycles, expected 1", budget);
        end
    endtask

    // Accept the pending command, optionally drop that port's request, then finish the transfer.
    task automatic serve(input int p, input bit clr);
        waitVld(12);
        cmd_rdy = 1'b1;
        cyc(1);
        cmd_rdy = 1'b0;
        if (clr) begin
            num[p] = '0;
            urg[p] = 1'b0;
        end
        xfer_done = 1'b1;
        cyc(1);
        xfer_done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prevVld = 1'b0;
        end else begin
            if (cmd_vld && !prevVld) begin
                if (expQ.size() == 0) begin
                    vecCnt++;
                    errCnt++;
                    haveCur = 1'b0;
                    $display("FAIL unexpected_cmd: port %0d issued, no command expected", cmd_port);
                end else begin
                    cur     = expQ.pop_front();
                    haveCur = 1'b1;
                end
            end
            if (cmd_vld && haveCur) begin
                chk("cmd_port", 64'(cmd_port), 64'(cur.port));
                chk("cmd_num",  64'(cmd_num),  64'(cur.num));
                chk("cmd_addr", 64'(cmd_addr), 64'(cur.addr));
                chk("cmd_rd",   64'(cmd_rd),   64'(cur.rd));
                chk("gnt",      64'(gnt),      64'd1 << cur.port);
            end
            prevVld = cmd_vld;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_rdy   = 1'b0;
        xfer_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            urg[i]  = 1'b0;
            num[i]  = '0;
            adr[i]  = '0;
            base[i] = '0;
        end
        adr[0] = 16'h0001; base[0] = 32'h0000_0100;
        adr[1] = 16'h0004; base[1] = 32'h0000_2000;
        adr[3] = 16'hFFFF; base[3] = 32'h3000_0000;
        adr[4] = 16'h0008; base[4] = 32'h0000_4000;
        repeat (3) @(posedge clk);
        #1;

        chk("rst_cmd_vld",  64'(cmd_vld),  0);
        chk("rst_cmd_port", 64'(cmd_port), 0);
        chk("rst_cmd_num",  64'(cmd_num),  0);
        chk("rst_cmd_addr", 64'(cmd_addr), 0);
        chk("rst_cmd_rd",   64'(cmd_rd),   0);
        chk("rst_gnt",      64'(gnt),      0);
        chk("rst_busy",     64'(busy),     0);
        rst_n = 1'b1;
        cyc(1);

        // Completion pulse while idle must be ignored.
        xfer_done = 1'b1;
        cyc(1);
        xfer_done = 1'b0;
        chk("idle_done_busy", 64'(busy), 0);
        cyc(1);
        chk("idle_done_vld", 64'(cmd_vld), 0);

        // Single request: latency, hold under backpressure, ignored done pulses.
        num[2] = 16'd5; adr[2] = 16'h0010; base[2] = 32'h0000_1000;
        pushExp(2, 16'd5, 32'h0000_1010, 1'b0);
        cyc(1);
        chk("lat_arb_vld",  64'(cmd_vld), 0);
        chk("lat_arb_busy", 64'(busy),    1);
        cyc(1);
        chk("lat_grant_vld", 64'(cmd_vld), 1);
        num[2] = 16'd9; adr[2] = 16'h0000; base[2] = 32'hDEAD_0000;
        cyc(1);
        xfer_done = 1'b1;
        cyc(1);
        xfer_done = 1'b0;
        chk("grant_done_vld", 64'(cmd_vld), 1);
        cyc(1);
        cmd_rdy   = 1'b1;
        xfer_done = 1'b1;
        cyc(1);
        cmd_rdy   = 1'b0;
        xfer_done = 1'b0;
        num[2]    = '0;
        chk("hs_done_vld",  64'(cmd_vld), 0);
        chk("hs_done_busy", 64'(busy),    1);
        chk("hs_done_gnt",  64'(gnt),     64'h04);
        cyc(2);
        chk("busy_hold", 64'(busy), 1);
        xfer_done = 1'b1;
        cyc(1);
        xfer_done = 1'b0;
        chk("done_busy", 64'(busy),    0);
        chk("done_gnt",  64'(gnt),     0);
        chk("done_vld",  64'(cmd_vld), 0);

        // Urgent first, then round-robin over the rest.
        num[1] = 16'd1; num[3] = 16'd2; num[4] = 16'd3; urg[4] = 1'b1;
        pushExp(4, 16'd3, 32'h0000_4008, 1'b1);
        pushExp(1, 16'd1, 32'h0000_2004, 1'b0);
        pushExp(3, 16'd2, 32'h3000_FFFF, 1'b0);
        serve(4, 1'b1);
        chk("turn_idle_vld", 64'(cmd_vld), 0);
        cyc(1);
        chk("turn_arb_vld", 64'(cmd_vld), 0);
        cyc(1);
        chk("turn_grant_vld", 64'(cmd_vld), 1);
        serve(1, 1'b1);
        serve(3, 1'b1);

        // Port 0 preempts without moving the pointer; port 5 reads and wraps both address and pointer.
        num[0] = 16'd7; num[1] = 16'd1; num[3] = 16'd2;
        num[5] = 16'd2; adr[5] = 16'h0020; base[5] = 32'hFFFF_FFF0;
        pushExp(0, 16'd7, 32'h0000_0101, 1'b0);
        pushExp(5, 16'd2, 32'h0000_0010, 1'b1);
        pushExp(1, 16'd1, 32'h0000_2004, 1'b0);
        pushExp(3, 16'd2, 32'h3000_FFFF, 1'b0);
        serve(0, 1'b1);
        serve(5, 1'b1);
        serve(1, 1'b1);
        serve(3, 1'b1);

        // Reset while port 3 holds a command.
        num[3] = 16'd2;
        pushExp(3, 16'd2, 32'h3000_FFFF, 1'b0);
        waitVld(12);
        cyc(1);
        chk("pre_rst_gnt", 64'(gnt), 64'h08);
        rst_n = 1'b0;
        #2;
        chk("midrst_vld",  64'(cmd_vld),  0);
        chk("midrst_gnt",  64'(gnt),      0);
        chk("midrst_busy", 64'(busy),     0);
        chk("midrst_port", 64'(cmd_port), 0);
        chk("midrst_num",  64'(cmd_num),  0);
        chk("midrst_addr", 64'(cmd_addr), 0);
        num[3] = '0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        num[1] = 16'd1; num[4] = 16'd3;
        pushExp(1, 16'd1, 32'h0000_2004, 1'b0);
        pushExp(4, 16'd3, 32'h0000_4008, 1'b1);
        serve(1, 1'b1);
        serve(4, 1'b1);

        // Port 2 pending against two permanently urgent ports.
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        num[2] = 16'd1; adr[2] = 16'h0010; base[2] = 32'h0000_1000;
        urg[3] = 1'b1; urg[4] = 1'b1;
        pushExp(3, 16'd0, 32'h3000_FFFF, 1'b0);
        pushExp(4, 16'd0, 32'h0000_4008, 1'b1);
`ifdef ITF_SCHED_AGE_EN
        pushExp(2, 16'd1, 32'h0000_1010, 1'b0);
`else
        pushExp(3, 16'd0, 32'h3000_FFFF, 1'b0);
`endif
        serve(3, 1'b0);
        serve(4, 1'b0);
        waitVld(12);
        num[2] = '0; urg[3] = 1'b0; urg[4] = 1'b0;
        serve(2, 1'b1);

        cyc(3);
        chk("end_vld", 64'(cmd_vld), 0);
        chk("scoreboard_drained", 64'(expQ.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
